// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// response error codes and the request legality check done at accept time.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10
  } lsu_err_t;

  // Misalignment (including illegal funct3, which is reported the same way)
  // wins over the out-of-range check.
  function automatic lsu_err_t check_req(input logic        we,
                                         input logic [2:0]  funct3,
                                         input logic [31:0] addr,
                                         input logic [31:0] mem_bytes);
    logic legal;
    logic misaligned;
    legal      = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_B:    legal = 1'b1;
      F3_H:    begin legal = 1'b1; misaligned = addr[0]; end
      F3_W:    begin legal = 1'b1; misaligned = (addr[1:0] != 2'b00); end
      F3_BU:   legal = !we;
      F3_HU:   begin legal = !we; misaligned = addr[0]; end
      default: legal = 1'b0;
    endcase
    if (!legal || misaligned) return ERR_MISALIGN;
    if (addr >= mem_bytes)    return ERR_RANGE;
    return ERR_OK;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: pulls a byte/half out of a memory word with
// sign or zero extension, and merges a store byte/half into a word.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_word,
  input  logic [15:0] i_store_data,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed little-endian lane and extend it for loads.
  always_comb begin
    w_byte      = i_word[{i_offset, 3'b000} +: 8];
    w_half      = i_word[{i_offset[1], 4'b0000} +: 16];
    o_load_data = i_word;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'd0, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'd0, w_half};
      default: o_load_data = i_word;
    endcase
  end

  // Replace only the addressed lane; every other byte keeps the read value.
  always_comb begin
    o_store_word = i_word;
    case (i_funct3)
      F3_B:    o_store_word[{i_offset, 3'b000} +: 8]     = i_store_data[7:0];
      F3_H:    o_store_word[{i_offset[1], 4'b0000} +: 16] = i_store_data;
      default: o_store_word = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit towards a word-write-only data memory with a one-cycle
// registered read. Sub-word stores are done as read-modify-write.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic [1:0]  o_resp_err,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_write_data,
  input  logic [31:0] i_mem_read_data
);

  lsu_state_t  r_state;
  lsu_state_t  w_next_state;
  logic        w_accept;
  lsu_err_t    w_req_err;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  lsu_err_t    r_resp_err;
  logic [31:0] w_load_data;
  logic [31:0] w_store_word;

  assign w_req_err = check_req(i_req_we, i_req_funct3, i_req_addr, MEM_BYTES);

  lsu_byte_lane u_lane (
    .i_funct3     (r_funct3),
    .i_offset     (r_addr[1:0]),
    .i_word       (i_mem_read_data),
    .i_store_data (r_wdata[15:0]),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  // Memory strobes come only from state and latched fields.
  assign o_req_ready      = (r_state == IDLE);
  assign o_mem_read       = (r_state == RD_REQ);
  assign o_mem_write      = (r_state == WR);
  assign o_mem_address    = {r_addr[31:2], 2'b00};
  assign o_mem_write_data = (r_state == WR) ? r_wdata : 32'd0;
  assign o_resp_valid     = r_resp_valid;
  assign o_resp_rdata     = r_resp_rdata;
  assign o_resp_err       = r_resp_err;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode; erroneous requests are answered straight from IDLE.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          w_accept = 1'b1;
          if (w_req_err != ERR_OK)                  w_next_state = IDLE;
          else if (i_req_we && i_req_funct3 == F3_W) w_next_state = WR;
          else                                       w_next_state = RD_REQ;
        end
      end
      RD_REQ:  w_next_state = RD_DATA;
      RD_DATA: w_next_state = r_we ? WR : IDLE;
      WR:      w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Request fields, merged store word and the one-cycle response pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_we         <= 1'b0;
      r_funct3     <= 3'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= ERR_OK;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= ERR_OK;
      if (w_accept) begin
        r_we     <= i_req_we;
        r_funct3 <= i_req_funct3;
        r_addr   <= i_req_addr;
        r_wdata  <= i_req_wdata;
        if (w_req_err != ERR_OK) begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= w_req_err;
        end
      end
      if (r_state == RD_DATA) begin
        if (r_we) begin
          r_wdata <= w_store_word;
        end else begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_load_data;
        end
      end
      if (r_state == WR) r_resp_valid <= 1'b1;
    end
  end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit: the initiator side of the data memory port (mem_read, mem_write, address, write_data, read_data) in the single-stage RISC core.
- Accepts one load/store request at a time from the core and sequences the memory's 1-cycle registered read.
- Performs read-modify-write for SB/SH, since the memory is word-write only, and sign/zero-extends LB/LH/LBU/LHU.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_BYTES, 1024, addressable bytes. Any address >= MEM_BYTES is out of range.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  2  00 ok, 01 misaligned, 10 out of range.
- mem_read  out  1  to data memory.
- mem_write  out  1  to data memory.
- mem_address  out  32  word-aligned: {addr_q[31:2], 2'b00}.
- mem_write_data  out  32  merged word.
- mem_read_data  in  32  memory output; valid only in the cycle after mem_read was high at a posedge.

Behaviour:
- Reset: state IDLE; resp_valid=0, resp_rdata=0, resp_err=00.
- Reset: mem_read=0, mem_write=0, mem_address=0, mem_write_data=0; req_ready=1 after the reset edge.
- Reset mid-operation abandons the transaction: no resp_valid, and no mem_write on any later edge.
- mem_read, mem_write, mem_address and mem_write_data are decoded from the state and registered fields only, never from req_* directly.
- Accept: on (req_valid && req_ready), latch we, funct3, addr, wdata. Request inputs are ignored outside IDLE.
- Error check at accept. Priority: misaligned (H with addr[0]=1, W with addr[1:0]!=0), then addr >= MEM_BYTES.
  - On error: stay in IDLE; next cycle resp_valid=1 with the err code and rdata=0. No memory access.
- Illegal funct3 (011, 110, 111, or 1xx on a store) is treated as misaligned (01).
- FSM states: IDLE, RD_REQ, RD_DATA, WR.
  - IDLE -> RD_REQ for loads, SB and SH. IDLE -> WR for SW.
  - RD_REQ: mem_read=1. -> RD_DATA.
  - RD_DATA (load): capture mem_read_data, extract and extend, register into resp_rdata, pulse resp_valid. -> IDLE.
  - RD_DATA (SB/SH): merge the store lane into the captured word, registered into wdata_q. -> WR.
  - WR: mem_write=1, mem_write_data=wdata_q. -> IDLE, pulse resp_valid (rdata=0, err=00).
- Latency, counted as posedge at accept to first cycle resp_valid is high:
  - error: 1 cycle
  - SW: 2 cycles
  - loads: 3 cycles
  - SB/SH: 4 cycles
- resp_valid cycle: state is IDLE, so a new request may be accepted in that same cycle.
- Lanes are little-endian.
  - Byte lane = addr_q[1:0]: data[8*off +: 8].
  - Half lane = addr_q[1]: data[16*addr_q[1] +: 16].
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- SB/SH replace only the selected lane with req_wdata[7:0] / [15:0]; all other bytes keep the read value.
- mem_read and mem_write are never high in the same cycle. Each is high exactly one cycle per access.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state encoding (IDLE, RD_REQ, RD_DATA, WR)
  - error codes (ERR_OK, ERR_MISALIGN, ERR_RANGE)
- Sub-module lsu_byte_lane: purely combinational.
  - Inputs: funct3, offset[1:0], word, store data.
  - Outputs: extended load value, merged store word.
- The top level holds the FSM and registers.

Test Plan:
- Preload word 0x14=0x00000005; LW 0x14 -> mem_read high for 1 cycle with mem_address=0x14; resp_valid 3 cycles after accept; rdata=0x00000005; err=00.
- SW 0x40 data 0xDEADBEEF -> mem_write 1 cycle, resp after 2 cycles. Then:
  - LB 0x43 -> 0xFFFFFFDE
  - LBU 0x43 -> 0x000000DE
  - LH 0x42 -> 0xFFFFDEAD
  - LHU 0x40 -> 0x0000BEEF
- SB 0x41 data 0x000000AA -> read then write 0xDEADAAEF; then SH 0x42 data 0x00001234 -> 0x1234AAEF. No mem_write before the read returns.
- LW 0x22 -> err 01; SH 0x41 -> err 01; LW 0x400 -> err 10. Each: resp 1 cycle after accept, mem_read=mem_write=0 throughout, rdata=0.
- SB 0x41 accepted, rst high during RD_DATA -> no mem_write, no resp_valid; req_ready=1 after the reset edge; word 0x40 unchanged on readback.
- Hold req_valid high continuously with LW 0x14 then LW 0x18 -> second accepted in the resp_valid cycle of the first; req_ready=0 in RD_REQ/RD_DATA; exactly 2 responses.
